// File: rtl/md_unit.sv
// md_unit: multicycle MIPS multiply/divide unit with HI/LO; madd/maddu built only under MDU_MADD_EN
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic is_mul, is_div, sgn, ovf, is_madd;
  logic [63:0] a_x, b_x, prod, acc;
  logic [31:0] dvs;
  logic signed [31:0] sq, sr;
  always_comb begin
    is_mul = md_op == OP_MULT || md_op == OP_MULTU || (MADD_EN && (md_op == OP_MADD || md_op == OP_MADDU));
    is_div = md_op == OP_DIV || md_op == OP_DIVU;
    sgn = op_q == OP_MULT || op_q == OP_MADD || op_q == OP_DIV;
    is_madd = MADD_EN && (op_q == OP_MADD || op_q == OP_MADDU);
    // sign-extended operands let one unsigned multiplier serve both signednesses
    a_x = {{32{sgn & a_q[31]}}, a_q};
    b_x = {{32{sgn & b_q[31]}}, b_q};
    prod = a_x * b_x;
    acc = {hi_q, lo_q} + prod;
    // dividing by 1 instead of -1 yields the wrapped 0x80000000 quotient with zero remainder
    ovf = a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
    dvs = ovf ? 32'd1 : b_q;
    sq = $signed(a_q) / $signed(dvs);
    sr = $signed(a_q) % $signed(dvs);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE) begin
      if (start && (is_mul || is_div)) begin
        state_d = RUN;
        cnt_d = is_div ? 4'd9 : 4'd4;
        op_d = md_op;
        a_d = A;
        b_d = B;
      end else if (start && md_op == OP_MTHI) hi_d = A;
      else if (start && md_op == OP_MTLO) lo_d = A;
    end else if (cnt_q == 4'd0) begin
      state_d = IDLE;
      if (op_q == OP_DIV || op_q == OP_DIVU) begin
        if (b_q != 32'd0) {hi_d, lo_d} = op_q == OP_DIV ? {sr, sq} : {a_q % b_q, a_q / b_q};
      end else {hi_d, lo_d} = is_madd ? acc : prod;
    end else cnt_d = cnt_q - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q == RUN;
  assign HI = hi_q;
  assign LO = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against an arithmetic HI/LO model
module tb_md_unit;
  logic clk = 1'b0, reset, start, busy;
  logic [3:0] md_op;
  logic [31:0] A, B, HI, LO;
  int tests = 0, fails = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  md_unit dut (.clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
               .busy(busy), .HI(HI), .LO(LO));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int latency(input logic [3:0] op);
    case (op)
      1, 2: return 5;
      3, 4: return 10;
      5, 6: return 0;
`ifdef MDU_MADD_EN
      7, 8: return 5;
`endif
      default: return -1;
    endcase
  endfunction
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] hl;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    hl = {m_hi, m_lo};
    case (op)
      1: hl = sa * sb;
      2: hl = ua * ub;
      3: if (b != 0) hl = {32'(sa % sb), 32'(sa / sb)};
      4: if (b != 0) hl = {a % b, a / b};
      5: hl[63:32] = a;
      6: hl[31:0] = a;
`ifdef MDU_MADD_EN
      7: hl = hl + 64'(sa * sb);
      8: hl = hl + 64'(ua * ub);
`endif
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endtask
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    int n;
    logic [31:0] oh, ol;
    n = latency(op);
    oh = m_hi;
    ol = m_lo;
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    tick;
    start = 1'b0;
    model(op, a, b);
    if (n <= 0) begin
      chk("busy_idle", busy, 1'b0);
      chk("hi_now", HI, m_hi);
      chk("lo_now", LO, m_lo);
    end else begin
      chk("busy_first", busy, 1'b1);
      for (int i = 1; i < n; i++) begin
        if (noise) begin
          A = $urandom;
          B = $urandom;
          start = 1'($urandom_range(0, 1));
          md_op = 4'($urandom_range(0, 15));
        end
        tick;
        start = 1'b0;
        chk("busy_run", busy, 1'b1);
        chk("hi_hold", HI, oh);
        chk("lo_hold", LO, ol);
      end
      tick;
      chk("busy_done", busy, 1'b0);
      chk("hi_wb", HI, m_hi);
      chk("lo_wb", LO, m_lo);
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = '0;
    A = '0;
    B = '0;
    tick;
    tick;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    do_op(4'd4, 32'd100, 32'd7, 1'b1);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);
    do_op(4'd5, 32'h1234, 32'd0, 1'b0);
    chk("mthi_hi", HI, 32'h1234);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    do_op(4'd3, 32'd5, 32'd0, 1'b1);
    chk("div0_lo", LO, 32'hFFFF_FFFD);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);
    do_op(4'd0, 32'd9, 32'd9, 1'b0);
    do_op(4'd12, 32'd9, 32'd9, 1'b0);
    start = 1'b1;
    md_op = 4'd1;
    A = 32'd7;
    B = 32'd9;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (6) tick;
    chk("late_busy", busy, 1'b0);
    chk("late_lo", LO, 32'd0);
    reset = 1'b1;
    start = 1'b1;
    md_op = 4'd1;
    A = 32'd3;
    B = 32'd3;
    tick;
    reset = 1'b0;
    start = 1'b0;
    chk("rstprio_busy", busy, 1'b0);
    tick;
    chk("rstprio_busy2", busy, 1'b0);
    do_op(4'd6, 32'd5, 32'd0, 1'b0);
    do_op(4'd5, 32'd0, 32'd0, 1'b0);
    do_op(4'd7, 32'd2, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    chk("madd_lo", LO, 32'd11);
`else
    chk("madd_lo", LO, 32'd5);
`endif
    chk("madd_hi", HI, 32'd0);
    for (int k = 0; k < 150; k++) do_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
